run_length_detector: RTL and testbench
======================================

// Module: run_length_detector
// PURPOSE
//  Parametrised Mealy run detector: watches a W-bit symbol stream, flags repeats (x)
//  and runs reaching a runtime threshold (y). Generalises the 1-bit 2/3-in-a-row FSM.
//  Adds: symbol width, saturating run counter, overlap mode, hit counter, sync clear.
//  Sits between a sampled input stage and control/status logic; outputs are combinational.
// PARAMETERS
//  DW       1    symbol width in bits
//  MAX_RUN  15   run-length counter saturation value (>=2)
//  CW       $clog2(MAX_RUN+1)  run counter / threshold width (derived, do not override)
//  HW       16   hit counter width
// PORTS
//  clk       in   1    clock, rising edge
//  reset     in   1    asynchronous, active-high
//  clear     in   1    sync clear: history, run_len, hit_cnt -> reset values
//  en        in   1    din valid this cycle; state frozen when 0
//  din       in   DW   input symbol
//  thresh    in   CW   run length for y; values <2 treated as 2
//  mode      in   1    0 = overlapping (y stays high while run continues), 1 = non-overlapping
//  x         out  1    Mealy: current symbol extends a run (effective length >= 2)
//  y         out  1    Mealy: effective run length >= thresh
//  run_len   out  CW   registered length of run ending at last accepted symbol
//  last_sym  out  DW   registered last accepted symbol
//  hit_cnt   out  HW   registered count of accepted cycles with y=1, saturating
// BEHAVIOUR
//  - States: IDLE (no history) and RUN (last_sym valid). Reset/clear -> IDLE.
//  - Reset values: state=IDLE, run_len=0, last_sym=0, hit_cnt=0. x=y=0 while in IDLE.
//  - Effective length L (comb): IDLE or din!=last_sym -> 1, else min(run_len+1, MAX_RUN).
//  - x = en & RUN & din==last_sym & (L >= 2). y = en & (L >= max(thresh,2)).
//  - thresh > MAX_RUN: y never asserts.
//  - Accepted cycle (en=1, clear=0):
//    last_sym <= din; state <= RUN.
//    run_len <= L, except mode=1 & y=1 -> run_len <= 0.
//    hit_cnt += y, saturating at all-ones.
//  - mode=1, run_len=0, state RUN: next equal symbol gives L=1, x=0.
//  - en=0: outputs x=y=0; all registers hold.
//  - Priority: reset > clear > en. Clear with en=1: sample discarded, x=y=0 that cycle.
//  - Reset mid-run: immediate async return to IDLE; next symbol always starts L=1.
//  - Counter arithmetic is unsigned; compare L against thresh zero-extended to CW.
//  - Latency: x/y valid same cycle as din (Mealy); run_len/hit_cnt update next edge.
// STRUCTURE
//  - Package run_det_pkg:
//    typedef enum logic {IDLE, RUN} run_state_t.
//    localparam THRESH_MIN = 2.
//  - Sub-module sat_counter #(W): saturating up-counter (inc, clr).
//    Used for hit_cnt; run_len stays inline because it loads L directly.
//  - One always_ff for state and registers. One always_comb for L, x, y.
// TESTING
//  DW=1, thresh=3, mode=0, en=1:
//   din 0,0,0,0 -> x 0,1,1,1; y 0,0,1,1; run_len ends 4; hit_cnt 2.
//  DW=1, thresh=3, mode=0:
//   din 1,1,0,0,0,1 -> x 0,1,0,1,1,0; y 0,0,0,0,1,0.
//  DW=4, thresh=2, mode=1:
//   din A,A,A,A -> y 0,1,0,1; run_len 1,0,1,0; hit_cnt 2.
//  MAX_RUN=15, thresh=15, mode=0:
//   20 identical symbols -> y first at 15th symbol, high through 20th; run_len holds 15.
//   thresh=0 behaves as thresh=2.
//  Mid-run events, run of 3 (run_len=3):
//   en=0 for 2 cycles -> x=y=0, run_len holds 3.
//   Resume with same symbol -> L=4.
//   clear pulse -> run_len=0, hit_cnt=0; next symbol x=0.
//   Async reset mid-run -> same result, asserted between clock edges.
//  HW=2: 5 hits -> hit_cnt saturates at 3.

Source files
------------

// File: rtl/run_length_detector_pkg.sv
// Shared types and constants for the run-length detector slice.
package run_det_pkg;
    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} run_state_t;
    localparam int THRESH_MIN = 2;
endpackage

// File: rtl/run_length_detector_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones.
module sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_cnt
);
    logic [W-1:0] r_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_inc && (r_cnt != '1))
            r_cnt <= r_cnt + W'(1);
    end

    assign o_cnt = r_cnt;
endmodule

// File: rtl/run_length_detector.sv
// Mealy run detector: flags repeated symbols (x) and runs reaching a
// runtime threshold (y), with saturating run length and hit counting.
module run_length_detector
    import run_det_pkg::*;
#(
    parameter int DW      = 1,
    parameter int MAX_RUN = 15,
    parameter int CW      = $clog2(MAX_RUN + 1),
    parameter int HW      = 16
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          en,
    input  logic [DW-1:0] din,
    input  logic [CW-1:0] thresh,
    input  logic          mode,
    output logic          x,
    output logic          y,
    output logic [CW-1:0] run_len,
    output logic [DW-1:0] last_sym,
    output logic [HW-1:0] hit_cnt
);
    localparam logic [CW-1:0] THR_MIN = CW'(THRESH_MIN);
    localparam logic [CW-1:0] L_REPEAT = CW'(2);
    localparam logic [CW-1:0] MAX_L   = CW'(MAX_RUN);
    localparam logic [CW:0]   MAX_EXT = (CW + 1)'(MAX_RUN);

    run_state_t    r_state;
    run_state_t    w_state_nxt;
    logic [CW-1:0] r_run_len;
    logic [DW-1:0] r_last_sym;
    logic [CW:0]   w_len_ext;
    logic [CW-1:0] w_len;
    logic [CW-1:0] w_thr;
    logic          w_match;
    logic          w_accept;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_run_len  <= '0;
            r_last_sym <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (clear) begin
                r_run_len  <= '0;
                r_last_sym <= '0;
            end else if (en) begin
                r_last_sym <= din;
                // Non-overlapping mode restarts counting after each hit
                r_run_len  <= (mode && y) ? '0 : w_len;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (clear)
            w_state_nxt = IDLE;
        else if (en)
            w_state_nxt = RUN;
    end

    always_comb begin
        w_accept  = en && !clear;
        w_match   = (r_state == RUN) && (din == r_last_sym);
        w_len_ext = {1'b0, r_run_len} + (CW + 1)'(1);
        w_len     = CW'(1);
        if (w_match)
            w_len = (w_len_ext >= MAX_EXT) ? MAX_L : w_len_ext[CW-1:0];
        w_thr = (thresh < THR_MIN) ? THR_MIN : thresh;
        x     = w_accept && w_match && (w_len >= L_REPEAT);
        y     = w_accept && (w_len >= w_thr);
    end

    sat_counter #(.W(HW)) u_hit_cnt (
        .clk   (clk),
        .reset (reset),
        .i_clr (clear),
        .i_inc (y),
        .o_cnt (hit_cnt)
    );

    assign run_len  = r_run_len;
    assign last_sym = r_last_sym;
endmodule

// File: tb/tb_run_length_detector.sv
// Directed bench: a 1-bit/2-bit-hit instance and a 4-bit/16-bit-hit instance
// share control inputs and see the same equality pattern on their symbols.
module tb_run_length_detector;
    logic        clk = 1'b0;
    logic        reset;
    logic        clear;
    logic        en;
    logic [3:0]  thresh;
    logic        mode;
    logic [0:0]  din1;
    logic [3:0]  din4;
    logic        x1, y1, x4, y4;
    logic [3:0]  rl1, rl4;
    logic [0:0]  ls1;
    logic [3:0]  ls4;
    logic [1:0]  hit1;
    logic [15:0] hit4;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    run_length_detector #(.DW(1), .MAX_RUN(15), .HW(2)) u_dut1 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .din(din1),
        .thresh(thresh), .mode(mode), .x(x1), .y(y1), .run_len(rl1),
        .last_sym(ls1), .hit_cnt(hit1)
    );

    run_length_detector #(.DW(4), .MAX_RUN(15), .HW(16)) u_dut4 (
        .clk(clk), .reset(reset), .clear(clear), .en(en), .din(din4),
        .thresh(thresh), .mode(mode), .x(x4), .y(y4), .run_len(rl4),
        .last_sym(ls4), .hit_cnt(hit4)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] d, input logic e,
                        input logic c, input logic ex, input logic ey);
        @(negedge clk);
        din4  = d;
        din1  = d[0];
        en    = e;
        clear = c;
        #1;
        chk({tag, ".x4"}, 32'(x4), 32'(ex));
        chk({tag, ".y4"}, 32'(y4), 32'(ey));
        chk({tag, ".x1"}, 32'(x1), 32'(ex));
        chk({tag, ".y1"}, 32'(y1), 32'(ey));
        @(posedge clk);
        #1;
        en    = 1'b0;
        clear = 1'b0;
    endtask

    initial begin
        reset  = 1'b1;
        clear  = 1'b0;
        en     = 1'b1;
        din1   = '0;
        din4   = '0;
        thresh = 4'd3;
        mode   = 1'b0;
        #3;
        chk("rst.run_len", 32'(rl4), 0);
        chk("rst.last_sym", 32'(ls4), 0);
        chk("rst.hit_cnt", 32'(hit4), 0);
        chk("rst.x", 32'(x4), 0);
        chk("rst.y", 32'(y4), 0);
        en = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Overlapping run of zeros, threshold 3
        step("t1a", 4'd0, 1, 0, 0, 0);
        step("t1b", 4'd0, 1, 0, 1, 0);
        step("t1c", 4'd0, 1, 0, 1, 1);
        step("t1d", 4'd0, 1, 0, 1, 1);
        chk("t1.run_len4", 32'(rl4), 4);
        chk("t1.run_len1", 32'(rl1), 4);
        chk("t1.hit4", 32'(hit4), 2);
        chk("t1.hit1", 32'(hit1), 2);

        // Alternating runs
        step("clr", 4'd0, 0, 1, 0, 0);
        step("t2a", 4'd1, 1, 0, 0, 0);
        step("t2b", 4'd1, 1, 0, 1, 0);
        step("t2c", 4'd0, 1, 0, 0, 0);
        step("t2d", 4'd0, 1, 0, 1, 0);
        step("t2e", 4'd0, 1, 0, 1, 1);
        step("t2f", 4'd1, 1, 0, 0, 0);
        chk("t2.last_sym", 32'(ls4), 1);
        chk("t2.run_len", 32'(rl4), 1);

        // Non-overlapping mode, threshold 2
        step("clr", 4'd0, 0, 1, 0, 0);
        thresh = 4'd2;
        mode   = 1'b1;
        step("t3a", 4'hA, 1, 0, 0, 0);
        chk("t3a.run_len", 32'(rl4), 1);
        step("t3b", 4'hA, 1, 0, 1, 1);
        chk("t3b.run_len", 32'(rl4), 0);
        step("t3c", 4'hA, 1, 0, 0, 0);
        chk("t3c.run_len", 32'(rl4), 1);
        step("t3d", 4'hA, 1, 0, 1, 1);
        chk("t3d.run_len", 32'(rl4), 0);
        chk("t3.hit4", 32'(hit4), 2);
        chk("t3.last_sym", 32'(ls4), 10);

        // Threshold at MAX_RUN with run saturation
        step("clr", 4'd0, 0, 1, 0, 0);
        thresh = 4'd15;
        mode   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step($sformatf("t4[%0d]", i), 4'd5, 1, 0, i > 0, i >= 14);
            chk($sformatf("t4[%0d].run_len", i), 32'(rl4), (i + 1 > 15) ? 15 : i + 1);
        end
        chk("t4.hit4", 32'(hit4), 6);
        chk("t4.hit1_sat", 32'(hit1), 3);

        // Thresholds below the minimum behave as 2
        step("clr", 4'd0, 0, 1, 0, 0);
        thresh = 4'd0;
        step("t5a", 4'd3, 1, 0, 0, 0);
        step("t5b", 4'd3, 1, 0, 1, 1);
        thresh = 4'd1;
        step("t5c", 4'd3, 1, 0, 1, 1);
        chk("t5.hit4", 32'(hit4), 2);

        // Mid-run enable gaps, clear and async reset
        step("clr", 4'd0, 0, 1, 0, 0);
        thresh = 4'd2;
        step("t6a", 4'd7, 1, 0, 0, 0);
        step("t6b", 4'd7, 1, 0, 1, 1);
        step("t6c", 4'd7, 1, 0, 1, 1);
        chk("t6.run_len", 32'(rl4), 3);
        step("t6.gap0", 4'd7, 0, 0, 0, 0);
        step("t6.gap1", 4'd7, 0, 0, 0, 0);
        chk("t6.gap.run_len", 32'(rl4), 3);
        chk("t6.gap.hit4", 32'(hit4), 2);
        step("t6.resume", 4'd7, 1, 0, 1, 1);
        chk("t6.resume.run_len", 32'(rl4), 4);
        chk("t6.resume.hit4", 32'(hit4), 3);
        step("t6.clr", 4'd7, 1, 1, 0, 0);
        chk("t6.clr.run_len", 32'(rl4), 0);
        chk("t6.clr.hit4", 32'(hit4), 0);
        chk("t6.clr.last_sym", 32'(ls4), 0);
        step("t6d", 4'd7, 1, 0, 0, 0);
        chk("t6d.run_len", 32'(rl4), 1);
        step("t6e", 4'd7, 1, 0, 1, 1);
        step("t6f", 4'd7, 1, 0, 1, 1);
        chk("t6f.run_len", 32'(rl4), 3);
        chk("t6f.hit4", 32'(hit4), 2);

        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t7.rst.run_len4", 32'(rl4), 0);
        chk("t7.rst.run_len1", 32'(rl1), 0);
        chk("t7.rst.hit4", 32'(hit4), 0);
        chk("t7.rst.last_sym", 32'(ls4), 0);
        #1;
        reset = 1'b0;
        step("t7a", 4'd7, 1, 0, 0, 0);
        chk("t7a.run_len", 32'(rl4), 1);
        chk("t7a.last_sym", 32'(ls4), 7);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
